// File: rtl/run_ctrl.sv
// run_ctrl: run-control sequencer for the single-cycle MIPS CPU.
//
// Decides when the in-flight instruction retires (pc_enable). It arbitrates
// between free-running execution, user pause/resume, single-stepping and
// the syscall halt. It also latches syscall-34 display values and keeps
// three performance counters.
//
// Ports
//   clk, rst            system clock; asynchronous active-high reset
//   pause, step         raw button levels, asynchronous to clk
//   halt_req            current instruction is a halting syscall (same cycle)
//   disp_req, disp_data current instruction is a display syscall, with its value
//   cond_taken          conditional branch taken this cycle
//   uncond_taken        current instruction is j/jal/jr
//   pc_enable           commit strobe: the instruction retires at the edge when 1
//   state               RUN=00 PAUSED=01 STEP=10 HALTED=11 (also the debug view)
//   led_data, led_valid last committed display value; led_valid is sticky.
//                       This is a flag, not a handshake: there is no ready
//                       and nothing ever clears it except reset.
//   total_cycles        committed instructions
//   condi_branch_num    committed taken conditional branches
//   uncondi_branch_num  committed unconditional jumps
module run_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pause,
  input  logic             step,
  input  logic             halt_req,
  input  logic             disp_req,
  input  logic [31:0]      disp_data,
  input  logic             cond_taken,
  input  logic             uncond_taken,
  output logic             pc_enable,
  output logic [1:0]       state,
  output logic [31:0]      led_data,
  output logic             led_valid,
  output logic [CNT_W-1:0] total_cycles,
  output logic [CNT_W-1:0] condi_branch_num,
  output logic [CNT_W-1:0] uncondi_branch_num
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_PAUSED = 2'b01,
    ST_STEP   = 2'b10,
    ST_HALTED = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t cur_st;

  // Button conditioning: two synchronizer flops, then a previous-value flop
  // used to turn a held level into a single one-cycle pulse per press.
  logic pause_s1, pause_s2, pause_prev;
  logic step_s1, step_s2, step_prev;
  logic pause_e, step_e;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pause_s1   <= 1'b0;
      pause_s2   <= 1'b0;
      pause_prev <= 1'b0;
      step_s1    <= 1'b0;
      step_s2    <= 1'b0;
      step_prev  <= 1'b0;
    end else begin
      pause_s1   <= pause;
      pause_s2   <= pause_s1;
      pause_prev <= pause_s2;
      step_s1    <= step;
      step_s2    <= step_s1;
      step_prev  <= step_s2;
    end
  end

  assign pause_e = pause_s2 & ~pause_prev;
  assign step_e  = step_s2 & ~step_prev;

  // Commit strobe. It has to be combinational: halt_req must block the
  // halting syscall from retiring in the very cycle it is decoded. In
  // HALTED, the resume press is also the cycle that retires the syscall.
  always_comb begin
    pc_enable = 1'b0;
    case (cur_st)
      ST_RUN:    pc_enable = ~halt_req;
      ST_STEP:   pc_enable = ~halt_req;
      ST_HALTED: pc_enable = pause_e;
      default:   pc_enable = 1'b0;
    endcase
  end

  // Sequencer. Within each state the first matching condition wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_st <= ST_RUN;
    end else begin
      case (cur_st)
        ST_RUN: begin
          // A halt outranks a simultaneous pause press; the press is lost.
          if (halt_req)     cur_st <= ST_HALTED;
          else if (pause_e) cur_st <= ST_PAUSED;
        end
        ST_PAUSED: begin
          // Resume outranks a simultaneous step press.
          if (pause_e)      cur_st <= ST_RUN;
          else if (step_e)  cur_st <= ST_STEP;
        end
        ST_STEP: begin
          // STEP lasts exactly one cycle.
          if (halt_req)     cur_st <= ST_HALTED;
          else              cur_st <= ST_PAUSED;
        end
        ST_HALTED: begin
          if (pause_e)      cur_st <= ST_RUN;
        end
        default:            cur_st <= ST_RUN;
      endcase
    end
  end

  assign state = cur_st;

  // Display latch. It follows the commit strobe, so a display syscall
  // never stalls, and nothing is latched while paused or halted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_data  <= 32'h0;
      led_valid <= 1'b0;
    end else if (pc_enable && disp_req) begin
      led_data  <= disp_data;
      led_valid <= 1'b1;
    end
  end

  // Performance counters. They wrap freely. Branch and jump flags are
  // counted independently, so both counters move if both flags are set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      total_cycles       <= '0;
      condi_branch_num   <= '0;
      uncondi_branch_num <= '0;
    end else if (pc_enable) begin
      total_cycles <= total_cycles + CNT_ONE;
      if (cond_taken)   condi_branch_num   <= condi_branch_num + CNT_ONE;
      if (uncond_taken) uncondi_branch_num <= uncondi_branch_num + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_run_ctrl.sv
module tb_run_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        pause, step, halt_req, disp_req, cond_taken, uncond_taken;
  logic [31:0] disp_data;

  logic        pc_enable, led_valid;
  logic [1:0]  state;
  logic [31:0] led_data, total_cycles, condi_branch_num, uncondi_branch_num;

  logic        pc_enable4, led_valid4;
  logic [1:0]  state4;
  logic [31:0] led_data4;
  logic [3:0]  tot4, cnd4, unc4;

  run_ctrl #(.CNT_W(32)) u_dut (
    .clk(clk), .rst(rst), .pause(pause), .step(step), .halt_req(halt_req),
    .disp_req(disp_req), .disp_data(disp_data), .cond_taken(cond_taken),
    .uncond_taken(uncond_taken), .pc_enable(pc_enable), .state(state),
    .led_data(led_data), .led_valid(led_valid), .total_cycles(total_cycles),
    .condi_branch_num(condi_branch_num), .uncondi_branch_num(uncondi_branch_num)
  );

  run_ctrl #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .pause(pause), .step(step), .halt_req(halt_req),
    .disp_req(disp_req), .disp_data(disp_data), .cond_taken(cond_taken),
    .uncond_taken(uncond_taken), .pc_enable(pc_enable4), .state(state4),
    .led_data(led_data4), .led_valid(led_valid4), .total_cycles(tot4),
    .condi_branch_num(cnd4), .uncondi_branch_num(unc4)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A button press becomes visible as a rising edge of the sampled level,
  // seen two clock samples late. The mode follows the run-control rules
  // directly; the counters are plain unbounded integers, compared modulo
  // the counter width.
  typedef enum int {M_RUN, M_PAUSED, M_STEP, M_HALTED} mode_t;
  mode_t           m_mode;
  bit              p_smp[3];
  bit              s_smp[3];
  longint unsigned m_tot, m_cond, m_unc;
  logic [31:0]     m_led;
  bit              m_led_v;

  task automatic model_reset();
    m_mode = M_RUN;
    for (int i = 0; i < 3; i++) begin
      p_smp[i] = 1'b0;
      s_smp[i] = 1'b0;
    end
    m_tot = 0; m_cond = 0; m_unc = 0;
    m_led = 32'h0; m_led_v = 1'b0;
  endtask

  function automatic bit m_pause_press();
    return p_smp[1] && !p_smp[2];
  endfunction

  function automatic bit m_step_press();
    return s_smp[1] && !s_smp[2];
  endfunction

  function automatic bit m_pc();
    if (m_mode == M_RUN || m_mode == M_STEP) return !halt_req;
    if (m_mode == M_HALTED) return m_pause_press();
    return 1'b0;
  endfunction

  function automatic logic [1:0] m_code(input mode_t m);
    case (m)
      M_RUN:    return 2'd0;
      M_PAUSED: return 2'd1;
      M_STEP:   return 2'd2;
      default:  return 2'd3;
    endcase
  endfunction

  task automatic m_edge();
    bit pc, pe, se;
    pe = m_pause_press();
    se = m_step_press();
    pc = m_pc();
    if (pc) begin
      m_tot++;
      if (cond_taken)   m_cond++;
      if (uncond_taken) m_unc++;
      if (disp_req) begin
        m_led   = disp_data;
        m_led_v = 1'b1;
      end
    end
    case (m_mode)
      M_RUN:    if (halt_req) m_mode = M_HALTED; else if (pe) m_mode = M_PAUSED;
      M_PAUSED: if (pe) m_mode = M_RUN; else if (se) m_mode = M_STEP;
      M_STEP:   m_mode = halt_req ? M_HALTED : M_PAUSED;
      default:  if (pe) m_mode = M_RUN;
    endcase
    p_smp[2] = p_smp[1]; p_smp[1] = p_smp[0]; p_smp[0] = pause;
    s_smp[2] = s_smp[1]; s_smp[1] = s_smp[0]; s_smp[0] = step;
  endtask

  // ---------------- driver ----------------
  logic last_pc;
  int   pc_pulses;

  task automatic clear_inputs();
    pause = 0; step = 0; halt_req = 0; disp_req = 0;
    disp_data = 32'h0; cond_taken = 0; uncond_taken = 0;
  endtask

  // Called in the low half of the clock with inputs already set. Checks
  // the commit strobe before the edge and everything registered after it.
  task automatic tick();
    #1;
    check("pc_enable", pc_enable, m_pc());
    check("pc_enable_w4", pc_enable4, m_pc());
    last_pc = pc_enable;
    if (pc_enable === 1'b1) pc_pulses++;
    @(posedge clk);
    m_edge();
    #1;
    check("state", state, m_code(m_mode));
    check("total_cycles", total_cycles, m_tot[31:0]);
    check("condi_branch_num", condi_branch_num, m_cond[31:0]);
    check("uncondi_branch_num", uncondi_branch_num, m_unc[31:0]);
    check("led_data", led_data, m_led);
    check("led_valid", led_valid, m_led_v);
    check("total_w4", tot4, m_tot[3:0]);
    check("condi_w4", cnd4, m_cond[3:0]);
    @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_state"}, state, 2'd0);
    check({tag, "_pc_enable"}, pc_enable, 1'b1);
    check({tag, "_led_data"}, led_data, 32'h0);
    check({tag, "_led_valid"}, led_valid, 1'b0);
    check({tag, "_total"}, total_cycles, 32'd0);
    check({tag, "_condi"}, condi_branch_num, 32'd0);
    check({tag, "_uncondi"}, uncondi_branch_num, 32'd0);
    check({tag, "_total_w4"}, tot4, 4'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    #1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Press a button for three cycles, then release it for three cycles.
  task automatic press(input bit p, input bit s);
    pause = p; step = s;
    repeat (3) tick();
    pause = 0; step = 0;
    repeat (3) tick();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        halt, pbtn, disp;
    logic [31:0] data;
    logic        cond, unc;
    logic        exp_pc;
    logic [1:0]  exp_st;
    int          exp_tot, exp_c, exp_u;
    logic [31:0] exp_led;
    logic        exp_v;
  } vec_t;

  vec_t tbl[13];

  bit saw_step;
  bit found;

  initial begin
    // Cycle sequence starting from reset: counting, display, halt with a
    // blocked display, then resume by a pause press while halted.
    tbl[0]  = '{0,0,0,32'h00,0,0, 1,2'd0, 1,0,0, 32'h00,0};
    tbl[1]  = '{0,0,0,32'h00,1,0, 1,2'd0, 2,1,0, 32'h00,0};
    tbl[2]  = '{0,0,0,32'h00,0,1, 1,2'd0, 3,1,1, 32'h00,0};
    tbl[3]  = '{0,0,0,32'h00,1,1, 1,2'd0, 4,2,2, 32'h00,0};
    tbl[4]  = '{0,0,1,32'h22,0,0, 1,2'd0, 5,2,2, 32'h22,1};
    tbl[5]  = '{1,0,0,32'h00,1,0, 0,2'd3, 5,2,2, 32'h22,1};
    tbl[6]  = '{1,0,1,32'h55,0,0, 0,2'd3, 5,2,2, 32'h22,1};
    tbl[7]  = '{1,1,0,32'h00,0,0, 0,2'd3, 5,2,2, 32'h22,1};
    tbl[8]  = '{1,1,0,32'h00,0,0, 0,2'd3, 5,2,2, 32'h22,1};
    tbl[9]  = '{1,1,1,32'h77,1,0, 1,2'd0, 6,3,2, 32'h77,1};
    tbl[10] = '{0,0,0,32'h00,0,0, 1,2'd0, 7,3,2, 32'h77,1};
    tbl[11] = '{0,0,0,32'h00,0,0, 1,2'd0, 8,3,2, 32'h77,1};
    tbl[12] = '{0,0,0,32'h00,0,1, 1,2'd0, 9,3,3, 32'h77,1};

    rst = 1'b1;
    clear_inputs();
    pc_pulses = 0;
    model_reset();
    @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;

    // Free run for 10 cycles.
    pc_pulses = 0;
    repeat (10) tick();
    check("free_run_pulses", pc_pulses, 10);
    check("free_run_total", total_cycles, 32'd10);
    check("free_run_state", state, 2'd0);

    // Table-driven vectors.
    do_reset();
    for (int i = 0; i < 13; i++) begin
      halt_req = tbl[i].halt; pause = tbl[i].pbtn; step = 1'b0;
      disp_req = tbl[i].disp; disp_data = tbl[i].data;
      cond_taken = tbl[i].cond; uncond_taken = tbl[i].unc;
      #1;
      check($sformatf("tbl%0d_pc", i), pc_enable, tbl[i].exp_pc);
      tick();
      check($sformatf("tbl%0d_state", i), state, tbl[i].exp_st);
      check($sformatf("tbl%0d_total", i), total_cycles, tbl[i].exp_tot);
      check($sformatf("tbl%0d_condi", i), condi_branch_num, tbl[i].exp_c);
      check($sformatf("tbl%0d_uncondi", i), uncondi_branch_num, tbl[i].exp_u);
      check($sformatf("tbl%0d_led", i), led_data, tbl[i].exp_led);
      check($sformatf("tbl%0d_led_valid", i), led_valid, tbl[i].exp_v);
    end
    clear_inputs();

    // Pause takes effect at the third edge; total frozen while paused.
    do_reset();
    pause = 1;
    tick(); tick();
    check("pause_edge2_still_run", state, 2'd0);
    tick();
    check("pause_edge3", state, 2'd1);
    pause = 0;
    repeat (4) tick();
    check("paused_frozen_total", total_cycles, 32'd3);

    // Two separate step presses: one commit each, back to PAUSED.
    for (int k = 0; k < 2; k++) begin
      pc_pulses = 0;
      press(1'b0, 1'b1);
      check($sformatf("step%0d_pulses", k), pc_pulses, 1);
      check($sformatf("step%0d_state", k), state, 2'd1);
    end
    check("step_total", total_cycles, 32'd5);

    // PAUSED: simultaneous pause and step presses resume without a step.
    pause = 1; step = 1; saw_step = 0;
    repeat (3) begin
      tick();
      if (state == 2'd2) saw_step = 1;
    end
    check("prio_pause_state", state, 2'd0);
    pause = 0; step = 0;
    repeat (3) begin
      tick();
      if (state == 2'd2) saw_step = 1;
    end
    check("prio_pause_no_step", saw_step, 1'b0);
    check("prio_pause_total", total_cycles, 32'd8);

    // Halt and resume.
    halt_req = 1;
    #1;
    check("halt_comb_pc", pc_enable, 1'b0);
    tick();
    check("halt_state", state, 2'd3);
    tick(); tick();
    check("halt_total_hold", total_cycles, 32'd8);
    pause = 1; pc_pulses = 0;
    repeat (3) tick();
    check("resume_pulses", pc_pulses, 1);
    check("resume_state", state, 2'd0);
    check("resume_total", total_cycles, 32'd9);
    halt_req = 0; pause = 0;
    repeat (3) tick();

    // Display in RUN does not stall; display while PAUSED is ignored.
    disp_req = 1; disp_data = 32'h0000_0022;
    #1;
    check("disp_no_stall", pc_enable, 1'b1);
    tick();
    check("disp_led", led_data, 32'h22);
    check("disp_valid", led_valid, 1'b1);
    disp_req = 0;
    press(1'b1, 1'b0);
    check("disp_paused_state", state, 2'd1);
    disp_req = 1; disp_data = 32'hdead_beef;
    tick(); tick();
    check("disp_paused_led", led_data, 32'h22);
    disp_req = 0;
    press(1'b1, 1'b0);
    check("resume2_state", state, 2'd0);

    // RUN: halt_req in the very cycle a pause press lands wins.
    pause = 1;
    tick(); tick();
    halt_req = 1;
    #1;
    check("prio_halt_pc", pc_enable, 1'b0);
    tick();
    check("prio_halt_state", state, 2'd3);
    halt_req = 0; pause = 0;
    repeat (4) tick();
    check("prio_halt_hold", state, 2'd3);
    press(1'b1, 1'b0);
    check("prio_halt_resume", state, 2'd0);

    // Counter wrap with the 4-bit instance.
    do_reset();
    cond_taken = 1;
    repeat (17) tick();
    cond_taken = 0;
    check("wrap_total_w4", tot4, 4'd1);
    check("wrap_condi_w4", cnd4, 4'd1);
    check("wrap_total_w32", total_cycles, 32'd17);

    // Randomized run against the model.
    do_reset();
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 5) == 0) pause = ~pause;
      if ($urandom_range(0, 5) == 0) step = ~step;
      halt_req     = ($urandom_range(0, 9) == 0);
      disp_req     = ($urandom_range(0, 7) == 0);
      disp_data    = $urandom;
      cond_taken   = $urandom_range(0, 1);
      uncond_taken = $urandom_range(0, 1);
      tick();
    end
    clear_inputs();

    // Asynchronous reset in the middle of a STEP cycle.
    do_reset();
    press(1'b1, 1'b0);
    step = 1; found = 0;
    for (int i = 0; i < 8 && !found; i++) begin
      tick();
      if (state == 2'd2) found = 1;
    end
    check("reach_step", found, 1'b1);
    step = 0;
    rst = 1;
    #1;
    check_reset_vals("async_rst_step");
    @(negedge clk);
    rst = 0;
    model_reset();
    tick();
    check("after_rst_step_state", state, 2'd0);

    // Asynchronous reset in the middle of HALTED.
    halt_req = 1;
    tick();
    check("pre_rst_halted", state, 2'd3);
    halt_req = 0;
    rst = 1;
    #1;
    check_reset_vals("async_rst_halt");
    @(negedge clk);
    rst = 0;
    model_reset();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
